vga_frame_scheduler: RTL and testbench
======================================

Name: vga_frame_scheduler

Overview:
- Sequences one frame of VGA updates per game tick and shares the single VGA adapter write port (plot/x/y/colour) between NUM_CLIENTS sprite painters (bird box, pipes, score).
- On each game_pulse it runs an erase pass over all clients in index order, then pulses game_tick_after_erase so game logic can move objects, then runs a draw pass.
- Clients stream pixels over a valid/ready handshake.
- The block sits between the painters and the VGA adapter.

Parameters:
NUM_CLIENTS, 3, number of painter clients; client 0 has the highest order.
MAX_PIXELS, 256, pixel budget per client per pass; forced end of pass on overrun.
CNT_W, 9, width of the per-pass pixel counter; must satisfy 2^CNT_W >= MAX_PIXELS.

Ports:
CLOCK_50  in  1  system clock, 50 MHz, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
game_pulse  in  1  one-cycle frame tick request
clear_flags  in  1  synchronous clear of the sticky flags
client_start  out  NUM_CLIENTS  one-cycle start pulse to the selected client
client_erase  out  1  1 during the erase pass, 0 during the draw pass
client_ready  out  NUM_CLIENTS  ready to the selected client during streaming
client_valid  in  NUM_CLIENTS  pixel valid per client
client_last  in  NUM_CLIENTS  marks the final pixel of the client's pass
client_x  in  8*NUM_CLIENTS  packed x; client i is bits [8i+7:8i]
client_y  in  7*NUM_CLIENTS  packed y
client_colour  in  3*NUM_CLIENTS  packed colour
plot  out  1  VGA write enable
x  out  8  VGA x
y  out  7  VGA y
colour  out  3  VGA colour
game_tick_after_erase  out  1  one-cycle pulse between the erase and draw passes
frame_done  out  1  one-cycle pulse at the end of the draw pass
busy  out  1  high in any state other than IDLE
overrun_flag  out  1  sticky: a client exceeded MAX_PIXELS
dropped_flag  out  1  sticky: a game_pulse was lost

Behaviour:
- Reset values: all outputs 0, state IDLE, idx 0, pending 0, counter 0. Reset mid-frame aborts the frame immediately and emits no pulses.
- States and transitions:
  - IDLE: if game_pulse or pending, clear pending, set erase=1, idx=0, go to START.
  - START: client_start[idx]=1 for exactly one cycle, counter=0, go to STREAM.
  - STREAM: client_ready[idx]=1; all other ready bits are 0.
  - ADVANCE (taken when a pass ends): if idx<NUM_CLIENTS-1, idx++ and go to START. Else if erase, go to UPDATE. Else go to DONE.
  - UPDATE: game_tick_after_erase=1 for one cycle, erase=0, idx=0, go to START.
  - DONE: frame_done=1 for one cycle, go to IDLE.
- Handshake:
  - A pixel is accepted when client_valid[idx] && client_ready[idx].
  - The accepted pixel's x, y and colour are registered. plot=1 on the following cycle only; latency is 1.
  - During the erase pass, the colour output is forced to 3'b000 regardless of the client's colour.
  - plot is 0 in every cycle with no accepted pixel in the previous cycle.
  - A valid that is not ready is ignored, and the client must hold its data.
  - A pass ends on an accepted pixel with client_last[idx]=1.
- Overrun:
  - counter increments on each accepted pixel.
  - If the MAX_PIXELS-th accepted pixel lacks last, it is treated as last and overrun_flag is set.
- Zero-pixel clients are not supported; every pass must deliver at least one pixel.
- game_pulse while busy:
  - If pending=0, set pending=1 (serviced on return to IDLE).
  - If pending=1 already, set dropped_flag.
  - game_pulse in IDLE in the same cycle that pending is set is serviced as one frame.
- clear_flags clears both sticky flags.
  - If clear_flags coincides with a set condition, the set wins.
- Packed-bus slicing uses idx; idx never exceeds NUM_CLIENTS-1.
- Minimum frame length: 2*NUM_CLIENTS*(2+pixels per client) + 3 cycles.

Test Plan:
- Three clients of 4/2/1 pixels with valid held high; pulse game_pulse. Required:
  - 7 erase plots, all with colour 000.
  - One game_tick_after_erase pulse.
  - 7 draw plots with client colours, in order 0, 1, 2.
  - frame_done once; busy falls the cycle after.
- Client 1 drops valid for 3 cycles mid-stream -> no plot in those gaps, x/y unchanged, no pixel lost or duplicated.
- Client 2 never asserts last with MAX_PIXELS=8 -> exactly 8 plots from client 2, overrun_flag=1, frame still completes. clear_flags then returns the flag to 0.
- Two game_pulses during a frame -> second frame runs back-to-back after frame_done, dropped_flag stays 0. A third pulse during the same frame sets dropped_flag.
- Assert reset in draw-pass STREAM of client 1 -> all outputs 0 within the same cycle. No frame_done. The next game_pulse starts a clean erase pass from client 0.
- Client 0 asserts valid on client 1's lanes while client 0 is selected -> client_ready[1]=0 and no plot from client 1 until its START.

Source files
------------

// File: rtl/vga_frame_scheduler.sv
// vga_frame_scheduler: per-tick erase/draw sequencer sharing one VGA write port among painter clients
module vga_frame_scheduler #(
  parameter int NUM_CLIENTS = 3,
  parameter int MAX_PIXELS = 256,
  parameter int CNT_W = 9
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     game_pulse,
  input  logic                     clear_flags,
  output logic [NUM_CLIENTS-1:0]   client_start,
  output logic                     client_erase,
  output logic [NUM_CLIENTS-1:0]   client_ready,
  input  logic [NUM_CLIENTS-1:0]   client_valid,
  input  logic [NUM_CLIENTS-1:0]   client_last,
  input  logic [8*NUM_CLIENTS-1:0] client_x,
  input  logic [7*NUM_CLIENTS-1:0] client_y,
  input  logic [3*NUM_CLIENTS-1:0] client_colour,
  output logic                     plot,
  output logic [7:0]               x,
  output logic [6:0]               y,
  output logic [2:0]               colour,
  output logic                     game_tick_after_erase,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     overrun_flag,
  output logic                     dropped_flag
);
  localparam int IW = NUM_CLIENTS > 1 ? $clog2(NUM_CLIENTS) : 1;
  typedef enum logic [2:0] {IDLE, START, STREAM, ADVANCE, UPDATE, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [CNT_W-1:0] count;
  logic erase_n, pending, pending_n, accept, at_cap, pass_end;
  assign accept = state == STREAM && client_valid[idx];
  assign at_cap = count == CNT_W'(MAX_PIXELS - 1);
  assign pass_end = accept && (client_last[idx] || at_cap);
  assign busy = state != IDLE;
  assign game_tick_after_erase = state == UPDATE;
  assign frame_done = state == DONE;
  assign client_start = state == START ? NUM_CLIENTS'(1) << idx : '0;
  assign client_ready = state == STREAM ? NUM_CLIENTS'(1) << idx : '0;
  always_comb begin
    state_n = state;
    idx_n = idx;
    erase_n = client_erase;
    pending_n = busy && (pending || game_pulse);
    case (state)
      IDLE: if (game_pulse || pending) begin
        state_n = START;
        erase_n = 1'b1;
        idx_n = '0;
      end
      START: state_n = STREAM;
      STREAM: state_n = pass_end ? ADVANCE : STREAM;
      ADVANCE: if (idx < IW'(NUM_CLIENTS - 1)) begin
        idx_n = idx + 1'b1;
        state_n = START;
      end else state_n = client_erase ? UPDATE : DONE;
      UPDATE: begin
        erase_n = 1'b0;
        idx_n = '0;
        state_n = START;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      client_erase <= 1'b0;
      pending <= 1'b0;
      count <= '0;
      plot <= 1'b0;
      x <= '0;
      y <= '0;
      colour <= '0;
      overrun_flag <= 1'b0;
      dropped_flag <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      client_erase <= erase_n;
      pending <= pending_n;
      count <= state == START ? '0 : accept ? count + 1'b1 : count;
      plot <= accept;
      if (accept) begin
        x <= client_x[8*idx +: 8];
        y <= client_y[7*idx +: 7];
        colour <= client_erase ? 3'b000 : client_colour[3*idx +: 3];
      end
      overrun_flag <= (pass_end && at_cap && !client_last[idx]) || (overrun_flag && !clear_flags);
      dropped_flag <= (game_pulse && busy && pending) || (dropped_flag && !clear_flags);
    end
  end
endmodule

// File: tb/tb_vga_frame_scheduler.sv
// tb_vga_frame_scheduler: random client streams checked against an ordered event model of each frame
module tb_vga_frame_scheduler;
  localparam int N = 3;
  localparam int MAXP = 8;
  logic clk = 0, rst = 1, game_pulse = 0, clear_flags = 0;
  logic [N-1:0] client_start, client_ready, client_valid, client_last;
  logic client_erase;
  logic [8*N-1:0] client_x;
  logic [7*N-1:0] client_y;
  logic [3*N-1:0] client_colour;
  logic plot, tick, frame_done, busy, overrun_flag, dropped_flag;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  int checks = 0, errors = 0;
  int done_cnt = 0, plot_cnt = 0, busy_cyc = 0;
  int n[N], kk[N], cur[N], pc[N], hold[N];
  bit nolast[N], act[N];
  int gap = 0, spur = 0, gap1 = 0;
  typedef struct {int kind; logic [17:0] pix;} item_t;
  item_t q[$];
  always #10 clk = ~clk;
  vga_frame_scheduler #(.NUM_CLIENTS(N), .MAX_PIXELS(MAXP), .CNT_W(4)) dut (
    .CLOCK_50(clk), .reset(rst), .game_pulse(game_pulse), .clear_flags(clear_flags),
    .client_start(client_start), .client_erase(client_erase), .client_ready(client_ready),
    .client_valid(client_valid), .client_last(client_last), .client_x(client_x),
    .client_y(client_y), .client_colour(client_colour), .plot(plot), .x(x), .y(y),
    .colour(colour), .game_tick_after_erase(tick), .frame_done(frame_done), .busy(busy),
    .overrun_flag(overrun_flag), .dropped_flag(dropped_flag));
  function automatic logic [17:0] pix(input int i, input int k, input int p);
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pcol;
    px = 8'(i * 67 + k * 13 + p * 29 + 5);
    py = 7'(i * 19 + k * 5 + p * 11 + 1);
    pcol = 3'(i + k * 3 + p * 5 + 1);
    return {px, py, pcol};
  endfunction
  function automatic bit exp_ovr();
    bit o = 0;
    for (int i = 0; i < N; i++) o |= nolast[i] || n[i] > MAXP;
    return o;
  endfunction
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask
  task automatic take(input string name, input int kind, output bit ok, output logic [17:0] p);
    checks++;
    ok = q.size() > 0 && q[0].kind == kind;
    p = '0;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got event kind %0d, required kind %0d", name, kind, q.size() > 0 ? q[0].kind : -1);
    end else p = q.pop_front().pix;
  endtask
  task automatic chk_zero(input string name);
    chk(name, {client_start, client_ready, client_erase, plot, x, y, colour, tick, frame_done, busy,
               overrun_flag, dropped_flag}, 0);
  endtask
  // Clients: stream their scripted pixels after a start; idle clients may babble on their lanes.
  initial begin
    logic [N-1:0] sr, ss, sv;
    logic [17:0] d;
    client_valid = 0; client_last = 0; client_x = 0; client_y = 0; client_colour = 0;
    for (int i = 0; i < N; i++) begin act[i] = 0; kk[i] = 0; cur[i] = 0; pc[i] = 0; hold[i] = 0; end
    forever begin
      @(negedge clk);
      sr = client_ready; ss = client_start; sv = client_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (rst) act[i] = 0;
        else if (ss[i]) begin act[i] = 1; kk[i] = 0; cur[i] = pc[i]; pc[i]++; hold[i] = 0; end
        else if (act[i] && sv[i] && sr[i]) begin
          kk[i]++;
          if (!nolast[i] && kk[i] == n[i]) act[i] = 0;
          if (gap1 != 0 && i == 1 && kk[i] == 1) hold[i] = 3;
        end
        if (act[i]) begin
          d = pix(i, kk[i], cur[i]);
          if (hold[i] > 0) begin client_valid[i] = 0; hold[i]--; end
          else client_valid[i] = (sv[i] && !sr[i]) || ($urandom_range(99) >= gap);
          client_last[i] = !nolast[i] && kk[i] == n[i] - 1;
        end else begin
          d = 18'($urandom);
          client_valid[i] = spur != 0 && $urandom_range(1) == 1;
          client_last[i] = $urandom_range(1) == 1;
        end
        {client_x[8*i +: 8], client_y[7*i +: 7], client_colour[3*i +: 3]} = d;
      end
    end
  end
  // Every cycle: plots, ticks and frame_done must appear in exactly the order the frame model predicts.
  logic [7:0] px_prev = 0;
  logic [6:0] py_prev = 0;
  bit prev_rst = 1;
  always @(negedge clk) begin
    bit ok;
    logic [17:0] p;
    logic [N-1:0] actv;
    if (!rst) begin
      for (int i = 0; i < N; i++) actv[i] = act[i];
      chk("start_onehot", $onehot0(client_start), 1);
      chk("ready_unstarted", client_ready & ~actv, 0);
      if (plot) begin
        plot_cnt++;
        take("plot_order", 0, ok, p);
        if (ok) chk("plot_pixel", {x, y, colour}, p);
      end else if (!prev_rst) chk("hold_xy", {x, y}, {px_prev, py_prev});
      if (tick) take("tick_order", 1, ok, p);
      if (frame_done) begin done_cnt++; take("done_order", 2, ok, p); end
      if (busy) busy_cyc++;
    end
    px_prev = x; py_prev = y; prev_rst = rst;
  end
  task automatic setup(input int n0, input int n1, input int n2, input bit nl2, input int g, input int s, input int g1);
    n[0] = n0; n[1] = n1; n[2] = n2;
    nolast[0] = 0; nolast[1] = 0; nolast[2] = nl2;
    gap = g; spur = s; gap1 = g1;
  endtask
  task automatic push_frames(input int nf);
    item_t it;
    int b[N];
    for (int i = 0; i < N; i++) b[i] = pc[i];
    for (int f = 0; f < nf; f++)
      for (int e = 0; e < 2; e++) begin
        for (int i = 0; i < N; i++) begin
          int cnt = (nolast[i] || n[i] > MAXP) ? MAXP : n[i];
          for (int k = 0; k < cnt; k++) begin
            it.kind = 0;
            it.pix = pix(i, k, b[i] + 2 * f + e);
            if (e == 0) it.pix[2:0] = 3'b000;
            q.push_back(it);
          end
        end
        it.kind = e + 1;
        it.pix = '0;
        q.push_back(it);
      end
  endtask
  task automatic pulse();
    @(posedge clk); #1 game_pulse = 1;
    @(posedge clk); #1 game_pulse = 0;
  endtask
  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 3000) begin @(negedge clk); #1; t++; end
    chk("frame_timeout", done_cnt >= target, 1);
  endtask
  task automatic frame_scen(input int extra);
    int nf = extra > 0 ? 2 : 1;
    int d0 = done_cnt;
    push_frames(nf);
    pulse();
    if (extra > 0) begin repeat (3) @(posedge clk); pulse(); chk("pending_no_drop", dropped_flag, 0); end
    if (extra > 1) begin repeat (2) @(posedge clk); pulse(); chk("drop_set", dropped_flag, 1); end
    wait_done(d0 + nf);
    @(posedge clk); #1;
    chk("busy_fall", busy, 0);
    chk("queue_empty", q.size(), 0);
    chk("overrun_flag", overrun_flag, exp_ovr());
    chk("dropped_flag", dropped_flag, extra > 1);
    @(posedge clk); #1 clear_flags = 1;
    @(posedge clk); #1 clear_flags = 0;
    chk("flags_cleared", {overrun_flag, dropped_flag}, 0);
  endtask
  initial begin
    int p0, b0, d0, t;
    setup(4, 2, 1, 0, 0, 0, 0);
    #5 chk_zero("reset_state");
    #30 rst = 0;
    repeat (3) @(posedge clk);
    #1 chk_zero("idle_after_reset");
    p0 = plot_cnt; b0 = busy_cyc;
    frame_scen(0);
    chk("frame421_plots", plot_cnt - p0, 14);
    chk("frame421_busy_cycles", busy_cyc - b0, 28);
    setup(3, 4, 2, 0, 0, 0, 1);
    frame_scen(0);
    setup(2, 3, 5, 1, 0, 0, 0);
    p0 = plot_cnt;
    frame_scen(0);
    chk("overrun_plots", plot_cnt - p0, 26);
    setup(2, 2, 2, 0, 0, 0, 0);
    frame_scen(1);
    frame_scen(2);
    setup(3, 3, 3, 0, 20, 1, 0);
    frame_scen(0);
    d0 = done_cnt;
    push_frames(1);
    pulse();
    t = 0;
    while (!(client_ready[1] && !client_erase) && t < 2000) begin @(negedge clk); t++; end
    chk("reach_draw_client1", client_ready[1] && !client_erase, 1);
    #2 rst = 1;
    #1 chk_zero("reset_midframe");
    q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst = 0;
    repeat (4) @(posedge clk);
    #1 chk("no_done_after_reset", done_cnt, d0);
    frame_scen(0);
    for (int r = 0; r < 8; r++) begin
      setup($urandom_range(10, 1), $urandom_range(10, 1), $urandom_range(10, 1), $urandom_range(7) == 0,
            $urandom_range(60), $urandom_range(1), 0);
      frame_scen($urandom_range(2));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
